// File: rtl/qos_pkg.sv
// Shared QoS datapath definitions: default widths and the drain-stage FSM states.
package qos_pkg;
  localparam int QOS_BW    = 6;
  localparam int QOS_CNT_W = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } lector_state_t;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the pointer names the FIFO favoured on a tie.
import qos_pkg::*;

module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       adv,
  output logic [1:0] grant
);
  logic rr;

  always_comb begin
    grant = req;
    if (req == 2'b11) grant = rr ? 2'b10 : 2'b01;
  end

  // Whoever wins hands the next tie to the other side.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                        rr <= 1'b0;
    else if (adv && (grant != 2'b00)) rr <= grant[0];
  end
endmodule

// File: rtl/lector_destinos.sv
// Drains D0/D1 FIFOs round-robin into one valid/ready stream tagged by destination.
// Optional per-destination delivery counters: define LECTOR_DEST_COUNTERS_EN.
import qos_pkg::*;

module lector_destinos #(
  parameter int BW    = QOS_BW,
  parameter int CNT_W = QOS_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             D0_empty,
  input  logic             D1_empty,
  input  logic             D0_error_output,
  input  logic             D1_error_output,
  input  logic [BW-1:0]    D0_data_out,
  input  logic [BW-1:0]    D1_data_out,
  output logic             D0_rd,
  output logic             D1_rd,
  input  logic             sink_ready,
  output logic             out_valid,
  output logic [BW-1:0]    out_data,
  output logic             out_dest,
  output logic [CNT_W-1:0] count_D0,
  output logic [CNT_W-1:0] count_D1,
  output logic             idle_out
);
  logic [1:0]    req, grant, occ;
  logic          skid_valid, skid_dest, pending, pend_dest;
  logic [BW-1:0] skid_data, new_data;
  logic          consume, can_issue, issue, out_free;
  lector_state_t state, state_nxt;

  assign req       = {~D1_empty & ~D1_error_output, ~D0_empty & ~D0_error_output};
  assign consume   = out_valid & sink_ready;
  assign out_free  = ~out_valid | sink_ready;
  assign occ       = {1'b0, out_valid} + {1'b0, skid_valid} + {1'b0, pending};
  // A full pair may still pop if the head leaves this cycle: a slot frees before data lands.
  assign can_issue = (occ <= 2'd1) | ((occ == 2'd2) & consume);
  assign issue     = can_issue & (|req) & ~reset;
  assign D0_rd     = issue & grant[0];
  assign D1_rd     = issue & grant[1];
  assign new_data  = pend_dest ? D1_data_out : D0_data_out;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .adv   (issue),
    .grant (grant)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_dest   <= 1'b0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_dest  <= 1'b0;
      pending    <= 1'b0;
      pend_dest  <= 1'b0;
    end else begin
      pending <= issue;
      if (issue) pend_dest <= grant[1];
      if (out_free) begin
        // Skid is older than the arriving word, so it moves up first.
        if (skid_valid) begin
          out_valid  <= 1'b1;
          out_data   <= skid_data;
          out_dest   <= skid_dest;
          skid_valid <= pending;
          if (pending) begin
            skid_data <= new_data;
            skid_dest <= pend_dest;
          end
        end else if (pending) begin
          out_valid <= 1'b1;
          out_data  <= new_data;
          out_dest  <= pend_dest;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (pending) begin
        skid_valid <= 1'b1;
        skid_data  <= new_data;
        skid_dest  <= pend_dest;
      end
    end
  end

`ifdef LECTOR_DEST_COUNTERS_EN
  logic [CNT_W-1:0] cnt0, cnt1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else if (consume) begin
      if (out_dest) cnt1 <= cnt1 + CNT_W'(1);
      else          cnt0 <= cnt0 + CNT_W'(1);
    end
  end

  assign count_D0 = cnt0;
  assign count_D1 = cnt1;
`else
  assign count_D0 = '0;
  assign count_D1 = '0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req) state_nxt = ACTIVE;
      ACTIVE:  if (~(|req) && (occ == 2'd0)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign idle_out = (state == IDLE);
endmodule

// File: tb/tb_lector_destinos.sv
// Randomised bench for lector_destinos: FIFO queues, pop-order scoreboard, rule-level arbitration model.
module tb_lector_destinos;
  localparam int BW    = 6;
  localparam int CNT_W = 2;
  localparam int CMOD  = 1 << CNT_W;
`ifdef LECTOR_DEST_COUNTERS_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic clk = 1'b0, reset = 1'b1;
  logic D0_empty = 1'b1, D1_empty = 1'b1, D0_error_output = 1'b0, D1_error_output = 1'b0;
  logic [BW-1:0] D0_data_out = '0, D1_data_out = '0;
  logic D0_rd, D1_rd, sink_ready = 1'b0, out_valid, out_dest, idle_out;
  logic [BW-1:0] out_data;
  logic [CNT_W-1:0] count_D0, count_D1;

  always #5 clk = ~clk;

  lector_destinos #(.BW(BW), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .D0_empty(D0_empty), .D1_empty(D1_empty),
    .D0_error_output(D0_error_output), .D1_error_output(D1_error_output),
    .D0_data_out(D0_data_out), .D1_data_out(D1_data_out),
    .D0_rd(D0_rd), .D1_rd(D1_rd), .sink_ready(sink_ready),
    .out_valid(out_valid), .out_data(out_data), .out_dest(out_dest),
    .count_D0(count_D0), .count_D1(count_D1), .idle_out(idle_out)
  );

  int total = 0, bad = 0;
  logic [BW-1:0] q0[$], q1[$];
  logic [BW:0]   exp_q[$], got_q[$];   // {dest, data}
  int            xfer_cyc[$];
  int  held, m_cnt0, m_cnt1, n_rd0, n_rd1, rd_mismatch, unstable, cyc;
  bit  m_rr, prev_stall;
  logic [BW:0] prev_word;

  task automatic refresh_flags();
    D0_empty = (q0.size() == 0);
    D1_empty = (q1.size() == 0);
  endtask

  task automatic clear_model();
    held = 0; m_rr = 1'b0; m_cnt0 = 0; m_cnt1 = 0; n_rd0 = 0; n_rd1 = 0;
    rd_mismatch = 0; unstable = 0; prev_stall = 1'b0; cyc = 0;
    exp_q.delete(); got_q.delete(); xfer_cyc.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    q0.delete(); q1.delete();
    D0_error_output = 1'b0; D1_error_output = 1'b0;
    refresh_flags();
    clear_model();
  endtask

  // One clock: sample at mid-cycle, model the spec's issue/arbitration rule, then update FIFO queues.
  task automatic tick();
    bit e0, e1, x, ok, g0, g1, r0, r1;
    #3;
    e0 = !D0_empty && !D0_error_output;
    e1 = !D1_empty && !D1_error_output;
    x  = (out_valid === 1'b1) && sink_ready;
    ok = (e0 || e1) && (held <= 1 || (held == 2 && x));
    g1 = e1 && (!e0 || m_rr);
    g0 = e0 && !g1;
    r0 = (D0_rd === 1'b1);
    r1 = (D1_rd === 1'b1);
    if (D0_rd !== (ok && g0) || D1_rd !== (ok && g1)) rd_mismatch++;
    if (prev_stall && (out_valid !== 1'b1 || {out_dest, out_data} !== prev_word)) unstable++;
    prev_stall = (out_valid === 1'b1) && !sink_ready;
    prev_word  = {out_dest, out_data};
    if (x) begin
      got_q.push_back({out_dest, out_data});
      xfer_cyc.push_back(cyc);
      if (out_dest) m_cnt1 = (m_cnt1 + 1) % CMOD;
      else          m_cnt0 = (m_cnt0 + 1) % CMOD;
    end
    if (ok) m_rr = g0;
    held = held + (ok ? 1 : 0) - (x ? 1 : 0);
    if (r0) n_rd0++;
    if (r1) n_rd1++;
    @(posedge clk); #1;
    cyc++;
    if (r0 && q0.size() > 0) begin
      D0_data_out = q0.pop_front();
      exp_q.push_back({1'b0, D0_data_out});
    end
    if (r1 && q1.size() > 0) begin
      D1_data_out = q1.pop_front();
      exp_q.push_back({1'b1, D1_data_out});
    end
    refresh_flags();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    #2;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    total++; if (idle_out !== 1'b1) begin bad++; $display("FAIL rst_idle: got %b want 1", idle_out); end
    total++; if ({out_dest, out_data} !== '0) begin bad++; $display("FAIL rst_out: got %h want 0", {out_dest, out_data}); end
    total++; if (count_D0 !== '0 || count_D1 !== '0) begin bad++; $display("FAIL rst_cnt: got %0d/%0d want 0/0", count_D0, count_D1); end
    do_reset();
    q0 = '{6'h05, 6'h06}; refresh_flags(); sink_ready = 1'b1; run(6);
    q0 = '{6'h11, 6'h12, 6'h13}; refresh_flags(); sink_ready = 1'b0; run(5);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rst_held: got %b want 1", out_valid); end
    reset = 1'b1; #2;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid: got %b want 0", out_valid); end
    total++; if (idle_out !== 1'b1) begin bad++; $display("FAIL rst_mid_idle: got %b want 1", idle_out); end
    total++; if (count_D0 !== '0) begin bad++; $display("FAIL rst_mid_cnt: got %0d want 0", count_D0); end
    total++; if (D0_rd !== 1'b0) begin bad++; $display("FAIL rst_mid_rd: got %b want 0", D0_rd); end
    @(posedge clk); #1;
    do_reset();
  endtask

  task automatic test_alternation();
    logic [BW:0] want[4];
    want = '{7'b0_100001, 7'b1_111111, 7'b0_101100, 7'b1_110101};
    do_reset();
    q0 = '{6'b10_0001, 6'b10_1100};
    q1 = '{6'b11_1111, 6'b11_0101};
    refresh_flags(); sink_ready = 1'b1;
    run(10);
    total++; if (got_q.size() != 4) begin bad++; $display("FAIL alt_len: got %0d want 4", got_q.size()); end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== want[i]) begin bad++; $display("FAIL alt_word%0d: got %b want %b", i, got_q[i], want[i]); end
    end
    total++; if (count_D0 !== CNT_W'(CNT_ON ? 2 : 0)) begin bad++; $display("FAIL alt_cnt0: got %0d", count_D0); end
    total++; if (count_D1 !== CNT_W'(CNT_ON ? 2 : 0)) begin bad++; $display("FAIL alt_cnt1: got %0d", count_D1); end
    total++; if (rd_mismatch != 0) begin bad++; $display("FAIL alt_arb: got %0d bad rd cycles want 0", rd_mismatch); end
    total++; if (idle_out !== 1'b1) begin bad++; $display("FAIL alt_idle: got %b want 1", idle_out); end
  endtask

  task automatic test_backpressure();
    logic [BW-1:0] w[4];
    do_reset();
    for (int i = 0; i < 4; i++) begin w[i] = BW'($urandom); q0.push_back(w[i]); end
    refresh_flags(); sink_ready = 1'b0;
    run(10);
    total++; if (n_rd0 != 2) begin bad++; $display("FAIL bp_rd: got %0d pulses want 2", n_rd0); end
    total++; if (unstable != 0) begin bad++; $display("FAIL bp_stable: got %0d changes want 0", unstable); end
    total++; if (out_data !== w[0]) begin bad++; $display("FAIL bp_head: got %h want %h", out_data, w[0]); end
    sink_ready = 1'b1;
    run(8);
    total++; if (got_q.size() != 4) begin bad++; $display("FAIL bp_len: got %0d want 4", got_q.size()); end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== {1'b0, w[i]}) begin bad++; $display("FAIL bp_word%0d: got %h want %h", i, got_q[i], {1'b0, w[i]}); end
    end
    if (xfer_cyc.size() == 4) begin
      total++;
      if (xfer_cyc[3] - xfer_cyc[0] != 3) begin bad++; $display("FAIL bp_b2b: got span %0d want 3", xfer_cyc[3] - xfer_cyc[0]); end
    end
    total++; if (rd_mismatch != 0) begin bad++; $display("FAIL bp_arb: got %0d want 0", rd_mismatch); end
  endtask

  task automatic test_error_mask();
    int d1 = 0, wrong = 0;
    do_reset();
    for (int i = 0; i < 3; i++) begin q0.push_back(BW'($urandom)); q1.push_back(BW'($urandom)); end
    refresh_flags(); D1_error_output = 1'b1;
    for (int i = 0; i < 20; i++) begin sink_ready = ($urandom_range(0, 2) != 0); tick(); end
    foreach (got_q[i]) if (got_q[i][BW]) d1++;
    total++; if (n_rd1 != 0) begin bad++; $display("FAIL err_rd1: got %0d pulses want 0", n_rd1); end
    total++; if (d1 != 0) begin bad++; $display("FAIL err_dest: got %0d D1 words want 0", d1); end
    total++; if (got_q.size() != 3) begin bad++; $display("FAIL err_len: got %0d want 3", got_q.size()); end
    D1_error_output = 1'b0; sink_ready = 1'b1;
    run(10);
    total++; if (got_q.size() != 6) begin bad++; $display("FAIL err_unmask_len: got %0d want 6", got_q.size()); end
    foreach (got_q[i]) if (i >= exp_q.size() || got_q[i] !== exp_q[i]) wrong++;
    total++; if (wrong != 0) begin bad++; $display("FAIL err_order: got %0d misordered want 0", wrong); end
    total++; if (rd_mismatch != 0) begin bad++; $display("FAIL err_arb: got %0d want 0", rd_mismatch); end
  endtask

  task automatic test_counter_wrap();
    do_reset();
    for (int i = 0; i < 5; i++) q0.push_back(BW'($urandom));
    refresh_flags(); sink_ready = 1'b1;
    run(12);
    total++; if (count_D0 !== CNT_W'(CNT_ON ? 1 : 0)) begin bad++; $display("FAIL wrap_cnt0: got %0d", count_D0); end
    total++; if (count_D1 !== '0) begin bad++; $display("FAIL wrap_cnt1: got %0d want 0", count_D1); end
  endtask

  task automatic test_random();
    int wrong = 0;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      sink_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) D0_error_output = ~D0_error_output;
      if ($urandom_range(0, 7) == 0) D1_error_output = ~D1_error_output;
      if (q0.size() < 3 && $urandom_range(0, 2) == 0) q0.push_back(BW'($urandom));
      if (q1.size() < 3 && $urandom_range(0, 2) == 0) q1.push_back(BW'($urandom));
      refresh_flags();
      tick();
    end
    D0_error_output = 1'b0; D1_error_output = 1'b0; sink_ready = 1'b1;
    run(20);
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL rnd_len: got %0d want %0d", got_q.size(), exp_q.size()); end
    foreach (got_q[i]) if (i >= exp_q.size() || got_q[i] !== exp_q[i]) wrong++;
    total++; if (wrong != 0) begin bad++; $display("FAIL rnd_order: got %0d misordered want 0", wrong); end
    total++; if (rd_mismatch != 0) begin bad++; $display("FAIL rnd_arb: got %0d want 0", rd_mismatch); end
    total++; if (unstable != 0) begin bad++; $display("FAIL rnd_stable: got %0d want 0", unstable); end
    total++; if (count_D0 !== CNT_W'(CNT_ON ? m_cnt0 : 0)) begin bad++; $display("FAIL rnd_cnt0: got %0d model %0d", count_D0, m_cnt0); end
    total++; if (count_D1 !== CNT_W'(CNT_ON ? m_cnt1 : 0)) begin bad++; $display("FAIL rnd_cnt1: got %0d model %0d", count_D1, m_cnt1); end
    total++; if (idle_out !== 1'b1) begin bad++; $display("FAIL rnd_idle: got %b want 1", idle_out); end
  endtask

  initial begin
    clear_model();
    @(posedge clk); #1;
    test_reset();
    test_alternation();
    test_backpressure();
    test_error_mask();
    test_counter_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lector_destinos.md
# lector_destinos

Downstream drain stage of the QoS datapath. Pops words from the two destination FIFOs (D0, D1) with round-robin arbitration, presents them on a single valid/ready output stream tagged with their destination, and keeps per-destination delivery counters. Sits directly after the D0/D1 FIFOs and replaces bench-driven `D0_rd`/`D1_rd` generation.

## Interface
- `BW`, 6, data word width (matches the FIFO data width).
- `CNT_W`, 8, width of each delivery counter.

- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `D0_empty`, `D1_empty`  in  1  FIFO empty flags
- `D0_error_output`, `D1_error_output`  in  1  FIFO error flags; an asserted flag masks that FIFO
- `D0_data_out`, `D1_data_out`  in  BW  FIFO read data, valid the cycle after the rd pulse
- `D0_rd`, `D1_rd`  out  1  pop strobes, combinational, at most one high per cycle
- `sink_ready`  in  1  downstream accepts `out_data` this cycle
- `out_valid`  out  1  `out_data` holds a word
- `out_data`  out  BW  delivered word
- `out_dest`  out  1  0 = from D0, 1 = from D1
- `count_D0`, `count_D1`  out  CNT_W  words delivered per destination
- `idle_out`  out  1  no work pending anywhere

## Operation
- Eligibility: Dn is eligible when `~Dn_empty & ~Dn_error_output`.
- Round-robin pointer `rr`, reset to 0 (D0 first):
  - With both FIFOs eligible, grant `rr`, then set `rr` to the other FIFO.
  - With one FIFO eligible, grant it and set `rr` to the other FIFO.
- Storage: output register plus one skid register. Occupancy = `out_valid + skid_valid + pending`, where `pending` flags a read in flight.
- Issue rule: assert the granted `Dn_rd` when occupancy ≤ 1, or when occupancy = 2 and `out_valid & sink_ready`.
- Capture: the cycle after the rd pulse, write `Dn_data_out` and the dest tag into the output register if it is free or being consumed. Otherwise write them into skid.
- Ordering: skid drains into the output register before any newer word. Delivery order equals pop order.
- Transfer: a word transfers on `out_valid & sink_ready`. `out_data`/`out_dest` hold stable while `out_valid & ~sink_ready`.
- Counters: `count_Dn` increments on each transfer tagged n and wraps modulo 2^CNT_W.
- FSM, states IDLE and ACTIVE:
  - IDLE → ACTIVE when either FIFO is eligible.
  - ACTIVE → IDLE when neither FIFO is eligible and occupancy = 0.
  - `idle_out` = (state == IDLE).
- Error mid-stream: the FIFO is masked from the next grant. A word already in flight is still delivered.
- Empty boundary: a FIFO whose empty flag is high in cycle t is not granted in t.

## Timing
- Reset values: `D0_rd` = `D1_rd` = 0, `out_valid` = 0, `out_data` = 0, `out_dest` = 0, counters = 0, `rr` = 0, state IDLE, `idle_out` = 1. Skid and pending are cleared.
- Reset mid-operation discards any in-flight or held word. The FIFO pop already taken is not replayed.
- Latency: rd in cycle t → `out_valid` high in cycle t+2 when the path is unobstructed.
- Throughput: with `sink_ready` held high and a source eligible, one word per cycle in steady state.
- Backpressure: with `sink_ready` low, at most 2 words are buffered and no rd issues beyond that.

## Configuration
- `LECTOR_DEST_COUNTERS_EN`:
  - Defined: `count_D0`/`count_D1` are implemented as described.
  - Undefined: both counter outputs are tied to 0 and the counter flops are absent. All other behaviour is identical.

## Structure
- Shared package `qos_pkg`:
  - FSM state enum `lector_state_t` (IDLE, ACTIVE).
  - Default localparams `QOS_BW = 6` and `QOS_CNT_W = 8`.
- Sub-module `rr_arbiter2`: two request bits plus advance enable → one-hot grant, owns the `rr` pointer.
- Skid/output registers and counters stay in the top module.

## Test plan
- Reset: assert `reset` mid-stream with a word held → next cycle `out_valid` = 0, counters = 0, `idle_out` = 1.
- Alternation:
  - Stimulus: D0 holds 6'b10_0001, 6'b10_1100; D1 holds 6'b11_1111, 6'b11_0101; `sink_ready` = 1.
  - Response: delivery order 10_0001/D0, 11_1111/D1, 10_1100/D0, 11_0101/D1.
  - Response: `count_D0` = `count_D1` = 2.
- Backpressure:
  - Stimulus: D0 holds 4 words, `sink_ready` = 0 for 10 cycles.
  - Response: exactly 2 `D0_rd` pulses, `out_data` stable.
  - Then `sink_ready` = 1 → all 4 words delivered in order on back-to-back cycles.
- Error mask: `D1_error_output` = 1 with both FIFOs non-empty → only `D0_rd` pulses, `out_dest` stays 0.
- Counter wrap: CNT_W = 2, deliver 5 words from D0 → `count_D0` = 1.
- Macro off: build without `LECTOR_DEST_COUNTERS_EN`, repeat the alternation scenario → identical data order, counters read 0.
